// File: rtl/reservation_station_pkg.sv
// Shared types and default sizes for the reservation station slice: operand/payload
// typedefs, the rs index type and the stored entry layout.
package reservation_station_pkg;

  localparam int unsigned DispWidth  = 3;
  localparam int unsigned RsSize     = 16;
  localparam int unsigned CdbWidth   = 3;
  localparam int unsigned IssueWidth = 3;

  typedef logic        bool;
  typedef logic [3:0]  opt_t;
  typedef logic [2:0]  fun_t;
  typedef logic [1:0]  sel_t;
  typedef logic [31:0] pc_t;
  typedef logic [31:0] imm_t;
  typedef logic [5:0]  phy_reg_t;
  typedef logic [4:0]  rob_idx_t;
  typedef logic [3:0]  lsq_idx_t;
  typedef logic [$clog2(RsSize)-1:0] rs_idx_t;

  typedef struct packed {
    opt_t           opt;
    fun_t           fun;
    sel_t [1:0]     sel;
    pc_t            pc;
    imm_t           imm;
    phy_reg_t [1:0] src;
    phy_reg_t       dst;
    rob_idx_t       rob_idx;
    lsq_idx_t       lsq_idx;
  } entry_t;

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch-to-reservation-station channel: slot advertisement back, renamed
// instructions forward, one lane per dispatch slot.
interface dispatch
  import reservation_station_pkg::*;
#(
  parameter int unsigned WIDTH = DispWidth
) ();

  bool      [WIDTH-1:0]      avail;
  rs_idx_t  [WIDTH-1:0]      rs_idx;
  bool      [WIDTH-1:0]      valid;
  opt_t     [WIDTH-1:0]      opt;
  fun_t     [WIDTH-1:0]      fun;
  sel_t     [WIDTH-1:0][1:0] sel;
  pc_t      [WIDTH-1:0]      pc;
  imm_t     [WIDTH-1:0]      imm;
  phy_reg_t [WIDTH-1:0][1:0] src;
  logic     [WIDTH-1:0][1:0] ready;
  phy_reg_t [WIDTH-1:0]      dst;
  rob_idx_t [WIDTH-1:0]      rob_idx;
  lsq_idx_t [WIDTH-1:0]      lsq_idx;

  modport rs (
    output avail, rs_idx,
    input  valid, opt, fun, sel, pc, imm, src, ready, dst, rob_idx, lsq_idx
  );

  modport front (
    input  avail, rs_idx,
    output valid, opt, fun, sel, pc, imm, src, ready, dst, rob_idx, lsq_idx
  );

endinterface

// File: rtl/reservation_station_psel_n.sv
// N-of-M priority selector: grant k carries the index of the k-th lowest set
// request bit; unused grants report index 0.
module psel_n #(
  parameter int unsigned N = 3,
  parameter int unsigned M = 16,
  localparam int unsigned IdxW = (M > 1) ? $clog2(M) : 1
) (
  input  logic [M-1:0]           req,
  output logic [N-1:0]           gnt,
  output logic [N-1:0][IdxW-1:0] idx
);

  always_comb begin
    int unsigned cnt;
    gnt = '0;
    idx = '0;
    cnt = 0;
    for (int unsigned j = 0; j < M; j++) begin
      if (req[j]) begin
        for (int unsigned l = 0; l < N; l++) begin
          if (cnt == l) begin
            gnt[l] = 1'b1;
            idx[l] = IdxW'(j);
          end
        end
        cnt = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: captures dispatched instructions, wakes operands from CDB
// broadcasts and issues fully ready entries lowest-index first.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned WIDTH       = DispWidth,
  parameter int unsigned RS_SIZE     = RsSize,
  parameter int unsigned CDB_WIDTH   = CdbWidth,
  parameter int unsigned ISSUE_WIDTH = IssueWidth
) (
  input  logic                              clock,
  input  logic                              reset,
  dispatch.rs                               disp,
  input  logic                              flush,
  input  bool      [CDB_WIDTH-1:0]          cdb_valid,
  input  phy_reg_t [CDB_WIDTH-1:0]          cdb_tag,
  output bool      [ISSUE_WIDTH-1:0]        issue_valid,
  input  bool      [ISSUE_WIDTH-1:0]        issue_ready,
  output opt_t     [ISSUE_WIDTH-1:0]        issue_opt,
  output fun_t     [ISSUE_WIDTH-1:0]        issue_fun,
  output sel_t     [ISSUE_WIDTH-1:0][1:0]   issue_sel,
  output pc_t      [ISSUE_WIDTH-1:0]        issue_pc,
  output imm_t     [ISSUE_WIDTH-1:0]        issue_imm,
  output phy_reg_t [ISSUE_WIDTH-1:0][1:0]   issue_src,
  output phy_reg_t [ISSUE_WIDTH-1:0]        issue_dst,
  output rob_idx_t [ISSUE_WIDTH-1:0]        issue_rob_idx,
  output lsq_idx_t [ISSUE_WIDTH-1:0]        issue_lsq_idx
);

  localparam int unsigned IdxW = $clog2(RS_SIZE);

  logic   [RS_SIZE-1:0]               busy_q, busy_d, eligible;
  logic   [RS_SIZE-1:0][1:0]          rdy_q, rdy_d;
  entry_t [RS_SIZE-1:0]               entry_q, entry_d;
  logic   [WIDTH-1:0]                 avail;
  logic   [WIDTH-1:0][IdxW-1:0]       free_idx;
  logic   [ISSUE_WIDTH-1:0][IdxW-1:0] iss_idx;
  entry_t [ISSUE_WIDTH-1:0]           iss_e;

  function automatic logic cdb_hit(input phy_reg_t tag, input bool [CDB_WIDTH-1:0] v,
                                   input phy_reg_t [CDB_WIDTH-1:0] t);
    logic hit;
    hit = 1'b0;
    for (int unsigned j = 0; j < CDB_WIDTH; j++) begin
      if (v[j] && t[j] == tag) hit = 1'b1;
    end
    return hit;
  endfunction

  // Advertisement depends on registered busy only, so no input reaches avail/rs_idx.
  psel_n #(.N(WIDTH), .M(RS_SIZE)) u_free_sel (
    .req (~busy_q),
    .gnt (avail),
    .idx (free_idx)
  );

  assign disp.avail  = avail;
  assign disp.rs_idx = free_idx;

  always_comb begin
    eligible = '0;
    for (int unsigned j = 0; j < RS_SIZE; j++) begin
      eligible[j] = busy_q[j] & rdy_q[j][0] & rdy_q[j][1];
    end
  end

  psel_n #(.N(ISSUE_WIDTH), .M(RS_SIZE)) u_issue_sel (
    .req (eligible),
    .gnt (issue_valid),
    .idx (iss_idx)
  );

  always_comb begin
    iss_e = '0;
    for (int unsigned l = 0; l < ISSUE_WIDTH; l++) begin
      if (issue_valid[l]) iss_e[l] = entry_q[iss_idx[l]];
    end
  end

  for (genvar l = 0; l < ISSUE_WIDTH; l++) begin : g_issue
    assign issue_opt[l]     = iss_e[l].opt;
    assign issue_fun[l]     = iss_e[l].fun;
    assign issue_sel[l]     = iss_e[l].sel;
    assign issue_pc[l]      = iss_e[l].pc;
    assign issue_imm[l]     = iss_e[l].imm;
    assign issue_src[l]     = iss_e[l].src;
    assign issue_dst[l]     = iss_e[l].dst;
    assign issue_rob_idx[l] = iss_e[l].rob_idx;
    assign issue_lsq_idx[l] = iss_e[l].lsq_idx;
  end

  always_comb begin
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    entry_d = entry_q;
    for (int unsigned j = 0; j < RS_SIZE; j++) begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (cdb_hit(entry_q[j].src[k], cdb_valid, cdb_tag)) rdy_d[j][k] = 1'b1;
      end
    end
    for (int unsigned l = 0; l < ISSUE_WIDTH; l++) begin
      if (issue_valid[l] && issue_ready[l]) busy_d[iss_idx[l]] = 1'b0;
    end
    // Free slots and issuing slots are disjoint, so allocation never races issue.
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (disp.valid[i] && avail[i]) begin
        busy_d[free_idx[i]]  = 1'b1;
        entry_d[free_idx[i]] = '{opt: disp.opt[i], fun: disp.fun[i], sel: disp.sel[i],
                                 pc: disp.pc[i], imm: disp.imm[i], src: disp.src[i],
                                 dst: disp.dst[i], rob_idx: disp.rob_idx[i],
                                 lsq_idx: disp.lsq_idx[i]};
        for (int unsigned k = 0; k < 2; k++) begin
          rdy_d[free_idx[i]][k] = disp.ready[i][k] |
                                  cdb_hit(disp.src[i][k], cdb_valid, cdb_tag);
        end
      end
    end
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      rdy_q   <= '0;
      entry_q <= '0;
    end else begin
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      entry_q <= entry_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        assert (!(disp.valid[i] && !avail[i]))
          else $error("dispatch lane %0d valid without an advertised slot", i);
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: advertisement, bypass/wakeup, full,
// stalled issue, flush and mid-run reset.
module tb_reservation_station;
  import reservation_station_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  bool      [2:0]      cdb_valid;
  phy_reg_t [2:0]      cdb_tag;
  bool      [2:0]      issue_valid, issue_ready;
  opt_t     [2:0]      issue_opt;
  fun_t     [2:0]      issue_fun;
  sel_t     [2:0][1:0] issue_sel;
  pc_t      [2:0]      issue_pc;
  imm_t     [2:0]      issue_imm;
  phy_reg_t [2:0][1:0] issue_src;
  phy_reg_t [2:0]      issue_dst;
  rob_idx_t [2:0]      issue_rob_idx;
  lsq_idx_t [2:0]      issue_lsq_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dispatch #(.WIDTH(3)) dif ();

  reservation_station dut (
    .clock         (clk),
    .reset         (rst),
    .disp          (dif),
    .flush         (flush),
    .cdb_valid     (cdb_valid),
    .cdb_tag       (cdb_tag),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_opt     (issue_opt),
    .issue_fun     (issue_fun),
    .issue_sel     (issue_sel),
    .issue_pc      (issue_pc),
    .issue_imm     (issue_imm),
    .issue_src     (issue_src),
    .issue_dst     (issue_dst),
    .issue_rob_idx (issue_rob_idx),
    .issue_lsq_idx (issue_lsq_idx)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int l, input int rob, input int s0, input int s1,
                     input logic [1:0] rdy);
    dif.valid[l]     = 1'b1;
    dif.opt[l]       = opt_t'(rob);
    dif.fun[l]       = fun_t'(l);
    dif.sel[l][0]    = sel_t'(rob);
    dif.sel[l][1]    = sel_t'(l);
    dif.pc[l]        = pc_t'(32'h1000 + rob * 4);
    dif.imm[l]       = imm_t'(rob * 3);
    dif.src[l][0]    = phy_reg_t'(s0);
    dif.src[l][1]    = phy_reg_t'(s1);
    dif.ready[l]     = rdy;
    dif.dst[l]       = phy_reg_t'(rob + 1);
    dif.rob_idx[l]   = rob_idx_t'(rob);
    dif.lsq_idx[l]   = lsq_idx_t'(rob);
  endtask

  task automatic cdb(input logic [2:0] v, input int t0, input int t1, input int t2);
    cdb_valid  = v;
    cdb_tag[0] = phy_reg_t'(t0);
    cdb_tag[1] = phy_reg_t'(t1);
    cdb_tag[2] = phy_reg_t'(t2);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cdb_valid = '0;
    cdb_tag = '0;
    issue_ready = '0;
    dif.valid = '0; dif.opt = '0; dif.fun = '0; dif.sel = '0; dif.pc = '0; dif.imm = '0;
    dif.src = '0; dif.ready = '0; dif.dst = '0; dif.rob_idx = '0; dif.lsq_idx = '0;
    step();
    step();
    rst = 1'b0;
    check_eq("reset_avail", 64'(dif.avail), 64'h7);
    check_eq("reset_rs_idx", 64'(dif.rs_idx), 64'h210);
    check_eq("reset_issue_valid", 64'(issue_valid), 64'h0);
    check_eq("reset_issue_rob", 64'(issue_rob_idx), 64'h0);

    // Three ready instructions issue the cycle after dispatch.
    issue_ready = 3'b111;
    put(0, 1, 0, 0, 2'b11);
    put(1, 2, 0, 0, 2'b11);
    put(2, 3, 0, 0, 2'b11);
    step();
    dif.valid = '0;
    check_eq("ready3_valid", 64'(issue_valid), 64'h7);
    for (int l = 0; l < 3; l++) check_eq("ready3_rob", 64'(issue_rob_idx[l]), 64'(l + 1));
    check_eq("ready3_pc1", 64'(issue_pc[1]), 64'h1008);
    check_eq("ready3_rs_idx", 64'(dif.rs_idx), 64'h543);
    step();
    check_eq("ready3_drained", 64'(issue_valid), 64'h0);
    check_eq("ready3_readv", 64'(dif.rs_idx), 64'h210);

    // Wakeup from a later CDB broadcast (duplicated tag on two lanes).
    put(0, 4, 7, 9, 2'b10);
    step();
    dif.valid = '0;
    check_eq("wake_wait", 64'(issue_valid), 64'h0);
    cdb(3'b011, 7, 7, 0);
    check_eq("wake_same_cycle", 64'(issue_valid), 64'h0);
    step();
    cdb(3'b000, 0, 0, 0);
    check_eq("wake_valid", 64'(issue_valid), 64'h1);
    check_eq("wake_rob", 64'(issue_rob_idx[0]), 64'd4);
    step();
    check_eq("wake_drained", 64'(issue_valid), 64'h0);

    // CDB bypass during the dispatch cycle.
    put(0, 5, 7, 9, 2'b10);
    cdb(3'b100, 0, 0, 7);
    step();
    dif.valid = '0;
    cdb(3'b000, 0, 0, 0);
    check_eq("bypass_valid", 64'(issue_valid), 64'h1);
    check_eq("bypass_rob", 64'(issue_rob_idx[0]), 64'd5);
    step();
    check_eq("bypass_drained", 64'(issue_valid), 64'h0);

    // Fill all 16 entries; entry j holds rob 10+j waiting on tag 20+j.
    for (int c = 0; c < 5; c++) begin
      for (int l = 0; l < 3; l++) put(l, 10 + c * 3 + l, 20 + c * 3 + l, 1, 2'b10);
      step();
    end
    dif.valid = '0;
    put(0, 25, 35, 1, 2'b10);
    step();
    dif.valid = '0;
    check_eq("full_avail", 64'(dif.avail), 64'h0);
    check_eq("full_rs_idx", 64'(dif.rs_idx), 64'h0);
    check_eq("full_issue", 64'(issue_valid), 64'h0);
    cdb(3'b001, 26, 0, 0);
    step();
    cdb(3'b000, 0, 0, 0);
    check_eq("full_wake_valid", 64'(issue_valid), 64'h1);
    check_eq("full_wake_rob", 64'(issue_rob_idx[0]), 64'd16);
    check_eq("full_still_full", 64'(dif.avail), 64'h0);
    step();
    check_eq("full_freed_avail", 64'(dif.avail), 64'h1);
    check_eq("full_freed_idx", 64'(dif.rs_idx), 64'h006);

    // Stall two issuable entries for five cycles.
    issue_ready = 3'b000;
    cdb(3'b011, 22, 29, 0);
    step();
    cdb(3'b000, 0, 0, 0);
    check_eq("stall_valid", 64'(issue_valid), 64'h3);
    for (int c = 0; c < 5; c++) begin
      step();
      check_eq("stall_hold_valid", 64'(issue_valid), 64'h3);
      check_eq("stall_hold_rob0", 64'(issue_rob_idx[0]), 64'd12);
      check_eq("stall_hold_rob1", 64'(issue_rob_idx[1]), 64'd19);
      check_eq("stall_hold_pc0", 64'(issue_pc[0]), 64'h1030);
    end
    issue_ready = 3'b111;
    step();
    check_eq("stall_release", 64'(issue_valid), 64'h0);
    check_eq("stall_avail", 64'(dif.avail), 64'h7);
    check_eq("stall_rs_idx", 64'(dif.rs_idx), 64'h962);

    // Drain three more to leave ten busy, then flush with a same-cycle dispatch.
    cdb(3'b111, 20, 21, 23);
    step();
    cdb(3'b000, 0, 0, 0);
    check_eq("pre_flush_issue", 64'(issue_valid), 64'h7);
    step();
    check_eq("pre_flush_rs_idx", 64'(dif.rs_idx), 64'h210);
    flush = 1'b1;
    put(0, 30, 0, 0, 2'b11);
    step();
    flush = 1'b0;
    dif.valid = '0;
    check_eq("flush_avail", 64'(dif.avail), 64'h7);
    check_eq("flush_rs_idx", 64'(dif.rs_idx), 64'h210);
    check_eq("flush_issue", 64'(issue_valid), 64'h0);
    // Fifteen fresh allocations must fit if every slot was freed.
    for (int c = 0; c < 5; c++) begin
      for (int l = 0; l < 3; l++) put(l, c * 3 + l, 50, 50, 2'b00);
      step();
    end
    dif.valid = '0;
    check_eq("refill_avail", 64'(dif.avail), 64'h1);
    check_eq("refill_rs_idx", 64'(dif.rs_idx), 64'h00f);
    check_eq("refill_issue", 64'(issue_valid), 64'h0);

    // Mid-run reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("rerst_avail", 64'(dif.avail), 64'h7);
    check_eq("rerst_rs_idx", 64'(dif.rs_idx), 64'h210);
    check_eq("rerst_issue", 64'(issue_valid), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
